// File: rtl/keypad_entry.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// keypad_entry: 4x4 keypad scanner with debounce and a packed-BCD entry buffer
// rev 1.0
// ============================================================================
module keypad_entry #(
  parameter int DEBOUNCE_MS = 20,
  parameter int NDIG        = 6,
  parameter int DWELL       = 4
) (
  input  logic              rst,
  input  logic              clk1k,
  input  logic [3:0]        row,
  output logic [3:0]        col,
  output logic [3:0]        key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              entry_done,
  output logic [4*NDIG-1:0] digits
);

  localparam int DW = $clog2(DWELL);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [7:0]    CNT_MAX    = 8'(DEBOUNCE_MS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

  state_t            state, state_nx;
  logic [3:0]        row_s1, row_s2;
  logic [DW-1:0]     dwell, dwell_nx;
  logic [7:0]        cnt, cnt_nx;
  logic [1:0]        col_idx, col_idx_nx;
  logic [3:0]        pat, pat_nx;
  logic [1:0]        row_idx;
  logic [3:0]        key_val;
  logic              single_low;
  logic [3:0]        key_code_nx;
  logic              key_valid_nx, key_held_nx, entry_done_nx;
  logic [4*NDIG-1:0] digits_nx;

  function automatic logic [3:0] key_map(input logic [3:0] idx);
    case (idx)
      4'd0:    key_map = 4'h1;
      4'd1:    key_map = 4'h2;
      4'd2:    key_map = 4'h3;
      4'd3:    key_map = 4'hA;
      4'd4:    key_map = 4'h4;
      4'd5:    key_map = 4'h5;
      4'd6:    key_map = 4'h6;
      4'd7:    key_map = 4'hB;
      4'd8:    key_map = 4'h7;
      4'd9:    key_map = 4'h8;
      4'd10:   key_map = 4'h9;
      4'd11:   key_map = 4'hC;
      4'd12:   key_map = 4'hE;
      4'd13:   key_map = 4'h0;
      4'd14:   key_map = 4'hF;
      default: key_map = 4'hD;
    endcase
  endfunction

  assign col = ~(4'b0001 << col_idx);

  always_comb begin
    single_low = 1'b0;
    case (row_s2)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
      default:                            single_low = 1'b0;
    endcase
  end

  always_comb begin
    row_idx = 2'd0;
    case (pat)
      4'b1101: row_idx = 2'd1;
      4'b1011: row_idx = 2'd2;
      4'b0111: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  assign key_val = key_map({row_idx, col_idx});

  always_ff @(posedge clk1k or negedge rst) begin
    if (!rst) begin
      row_s1     <= 4'hF;
      row_s2     <= 4'hF;
      state      <= SCAN;
      dwell      <= '0;
      cnt        <= '0;
      col_idx    <= 2'd0;
      pat        <= 4'hF;
      key_code   <= 4'h0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
      entry_done <= 1'b0;
      digits     <= '0;
    end else begin
      row_s1     <= row;
      row_s2     <= row_s1;
      state      <= state_nx;
      dwell      <= dwell_nx;
      cnt        <= cnt_nx;
      col_idx    <= col_idx_nx;
      pat        <= pat_nx;
      key_code   <= key_code_nx;
      key_valid  <= key_valid_nx;
      key_held   <= key_held_nx;
      entry_done <= entry_done_nx;
      digits     <= digits_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    dwell_nx      = dwell;
    cnt_nx        = cnt;
    col_idx_nx    = col_idx;
    pat_nx        = pat;
    key_code_nx   = key_code;
    key_valid_nx  = 1'b0;
    key_held_nx   = key_held;
    entry_done_nx = 1'b0;
    digits_nx     = digits;
    case (state)
      SCAN: begin
        if (dwell == DWELL_LAST) begin
          dwell_nx = '0;
          if (single_low) begin
            pat_nx   = row_s2;
            cnt_nx   = 8'd1;
            state_nx = DEBOUNCE;
          end else begin
            col_idx_nx = col_idx + 2'd1;
          end
        end else begin
          dwell_nx = dwell + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (row_s2 != pat) begin
          state_nx   = SCAN;
          col_idx_nx = col_idx + 2'd1;
          cnt_nx     = 8'd0;
        end else if (cnt == CNT_MAX) begin
          // Accept: the buffer update lands on the same edge as key_valid.
          state_nx     = PRESSED;
          cnt_nx       = 8'd0;
          key_code_nx  = key_val;
          key_valid_nx = 1'b1;
          key_held_nx  = 1'b1;
          if (key_val <= 4'd9) begin
            digits_nx      = digits << 4;
            digits_nx[3:0] = key_val;
          end else if (key_val == 4'hE) begin
            digits_nx = '0;
          end else if (key_val == 4'hF) begin
            entry_done_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      PRESSED: begin
        if (row_s2 == 4'hF) begin
          state_nx = RELEASE;
          cnt_nx   = 8'd1;
        end
      end
      default: begin
        if (row_s2 != 4'hF) begin
          state_nx = PRESSED;
          cnt_nx   = 8'd0;
        end else if (cnt == CNT_MAX) begin
          key_held_nx = 1'b0;
          state_nx    = SCAN;
          col_idx_nx  = col_idx + 2'd1;
          dwell_nx    = '0;
          cnt_nx      = 8'd0;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
    endcase
  end

endmodule
`default_nettype wire
